// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use stall / branch flush control plus registered forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs_id,
    input  logic [4:0]       Rt_id,
    input  logic             uses_rt_id,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    input  logic [4:0]       WriteReg_ex,
    input  logic             regwrite_mem,
    input  logic [4:0]       WriteReg_mem,
    input  logic             branch_taken,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_hazard;
    logic w_stall_evt;
    logic w_flush_evt;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (regwrite_ex && (WriteReg_ex != 5'd0) && (WriteReg_ex == src))
            return 2'b10;
        else if (regwrite_mem && (WriteReg_mem != 5'd0) && (WriteReg_mem == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_hazard = memread_ex && (WriteReg_ex != 5'd0) &&
                   ((WriteReg_ex == Rs_id) || (uses_rt_id && (WriteReg_ex == Rt_id)));

        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        state_d     = RUN;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;

        // Reset holds the pipeline frozen with a bubble; branch outranks any stall.
        if (!RST) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            w_flush_evt = 1'b1;
        end else if ((state_q == RUN) && w_hazard) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
            state_d     = STALLED;
            w_stall_evt = 1'b1;
        end

        fwd_a_d = IDEX_bubble ? 2'b00 : fwd_sel(Rs_id);
        fwd_b_d = IDEX_bubble ? 2'b00 : fwd_sel(Rt_id);

        stall_cnt_d = stall_cnt_q;
        if (w_stall_evt && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + C_ONE;

        flush_cnt_d = flush_cnt_q;
        if (w_flush_evt && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + C_ONE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= RUN;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ForwardA    = fwd_a_q;
    assign ForwardB    = fwd_b_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed and random checks of hazard_ctrl against a bench model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] Rs_id = '0, Rt_id = '0, WriteReg_ex = '0, WriteReg_mem = '0;
    logic       uses_rt_id = 1'b0, memread_ex = 1'b0, regwrite_ex = 1'b0;
    logic       regwrite_mem = 1'b0, branch_taken = 1'b0;

    logic        a_pc, a_ifid, a_flush, a_bub;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifid, b_flush, b_bub;
    logic [1:0]  b_fa, b_fb;
    logic [3:0]  b_sc, b_fc;

    hazard_ctrl #(.CNT_W(16)) u_dut16 (
        .CLK(CLK), .RST(RST), .Rs_id(Rs_id), .Rt_id(Rt_id), .uses_rt_id(uses_rt_id),
        .memread_ex(memread_ex), .regwrite_ex(regwrite_ex), .WriteReg_ex(WriteReg_ex),
        .regwrite_mem(regwrite_mem), .WriteReg_mem(WriteReg_mem), .branch_taken(branch_taken),
        .PC_write(a_pc), .IFID_write(a_ifid), .IFID_flush(a_flush), .IDEX_bubble(a_bub),
        .ForwardA(a_fa), .ForwardB(a_fb), .stall_count(a_sc), .flush_count(a_fc)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .Rs_id(Rs_id), .Rt_id(Rt_id), .uses_rt_id(uses_rt_id),
        .memread_ex(memread_ex), .regwrite_ex(regwrite_ex), .WriteReg_ex(WriteReg_ex),
        .regwrite_mem(regwrite_mem), .WriteReg_mem(WriteReg_mem), .branch_taken(branch_taken),
        .PC_write(b_pc), .IFID_write(b_ifid), .IFID_flush(b_flush), .IDEX_bubble(b_bub),
        .ForwardA(b_fa), .ForwardB(b_fb), .stall_count(b_sc), .flush_count(b_fc)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: whether the previous edge took a stall, the forward selects
    // loaded at the last edge, and unbounded event tallies.
    bit m_stalled = 1'b0;
    int m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;

    function automatic bit m_hazard();
        return memread_ex && (WriteReg_ex != 0) &&
               ((WriteReg_ex == Rs_id) || (uses_rt_id && (WriteReg_ex == Rt_id)));
    endfunction

    function automatic int m_fwd(input logic [4:0] src);
        if (regwrite_ex && WriteReg_ex != 0 && WriteReg_ex == src) return 2;
        if (regwrite_mem && WriteReg_mem != 0 && WriteReg_mem == src) return 1;
        return 0;
    endfunction

    // {PC_write, IFID_write, IFID_flush, IDEX_bubble}
    function automatic logic [3:0] m_ctl();
        if (!RST)         return 4'b0001;
        if (branch_taken) return 4'b1111;
        if (m_stalled)    return 4'b1100;
        if (m_hazard())   return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_stalled = 1'b0;
            m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
        end else begin : upd
            logic [3:0] c;
            bit stall;
            c     = m_ctl();
            stall = !branch_taken && !m_stalled && m_hazard();
            m_fa  = c[0] ? 0 : m_fwd(Rs_id);
            m_fb  = c[0] ? 0 : m_fwd(Rt_id);
            if (stall) m_sc++;
            if (branch_taken) m_fc++;
            m_stalled = stall;
        end
    end

    always @(negedge CLK) begin : cmp
        logic [3:0] e;
        e = m_ctl();
        check("PC_write",    a_pc,    e[3]);
        check("IFID_write",  a_ifid,  e[2]);
        check("IFID_flush",  a_flush, e[1]);
        check("IDEX_bubble", a_bub,   e[0]);
        check("ForwardA",    a_fa,    m_fa);
        check("ForwardB",    a_fb,    m_fb);
        check("stall_count", a_sc,    sat(m_sc, 65535));
        check("flush_count", a_fc,    sat(m_fc, 65535));
        check("PC_write_w4", b_pc,    e[3]);
        check("bubble_w4",   b_bub,   e[0]);
        check("ForwardA_w4", b_fa,    m_fa);
        check("ForwardB_w4", b_fb,    m_fb);
        check("stall_cnt_w4", b_sc,   sat(m_sc, 15));
        check("flush_cnt_w4", b_fc,   sat(m_fc, 15));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_idle();
        Rs_id = 0; Rt_id = 0; WriteReg_ex = 0; WriteReg_mem = 0;
        uses_rt_id = 0; memread_ex = 0; regwrite_ex = 0; regwrite_mem = 0; branch_taken = 0;
    endtask

    task automatic set_load_hazard();
        set_idle();
        memread_ex = 1; regwrite_ex = 1; WriteReg_ex = 8; Rs_id = 8;
    endtask

    initial begin
        #1 RST = 1'b0;
        #2;
        check("rst_pc",    a_pc,  0);
        check("rst_ifid",  a_ifid, 0);
        check("rst_flush", a_flush, 0);
        check("rst_bub",   a_bub, 1);
        check("rst_fa",    a_fa,  0);
        check("rst_sc",    a_sc,  0);
        repeat (2) tick();
        RST = 1'b1;
        tick();

        // Load-use stall, then the load reaches MEM while ID waits.
        set_load_hazard();
        #1;
        check("lu_pc0",  a_pc,  0);
        check("lu_bub1", a_bub, 1);
        tick();
        set_idle();
        Rs_id = 8; regwrite_mem = 1; WriteReg_mem = 8;
        #1;
        check("lu_pc1",  a_pc,  1);
        check("lu_bub0", a_bub, 0);
        check("lu_sc",   a_sc,  1);
        check("lu_fa0",  a_fa,  0);
        tick();
        set_idle();
        #1;
        check("lu_fa01", a_fa, 1);

        // Both stages write r5: EX/MEM wins on both operands.
        regwrite_ex = 1; WriteReg_ex = 5; regwrite_mem = 1; WriteReg_mem = 5;
        Rs_id = 5; Rt_id = 5;
        tick();
        #1;
        check("dbl_fa", a_fa, 2);
        check("dbl_fb", a_fb, 2);

        // r0 destination never stalls or forwards.
        set_idle();
        memread_ex = 1; regwrite_ex = 1; WriteReg_ex = 0; Rs_id = 0;
        #1;
        check("z_pc",  a_pc,  1);
        check("z_bub", a_bub, 0);
        tick();
        #1;
        check("z_fa", a_fa, 0);
        check("z_sc", a_sc, 1);

        // Branch together with a load-use hazard.
        set_load_hazard();
        branch_taken = 1;
        #1;
        check("br_flush", a_flush, 1);
        check("br_bub",   a_bub,   1);
        check("br_pc",    a_pc,    1);
        tick();
        #1;
        check("br_fc", a_fc, 1);
        check("br_sc", a_sc, 1);

        // Persistent hazard: a stall every other edge, 20 more stalls.
        set_load_hazard();
        repeat (40) tick();
        #1;
        check("sat_w4",  b_sc, 15);
        check("sat_w16", a_sc, 21);

        // Reset while STALLED.
        tick();
        #1;
        check("rs_stalled_pc", a_pc, 1);
        RST = 1'b0;
        #1;
        check("rs_pc",  a_pc,  0);
        check("rs_bub", a_bub, 1);
        check("rs_sc",  a_sc,  0);
        check("rs_fc",  a_fc,  0);
        check("rs_fa",  a_fa,  0);
        tick();
        RST = 1'b1;
        #1;
        check("rs_run_pc", a_pc, 0);
        tick();
        #1;
        check("rs_run_sc", a_sc, 1);

        // Random phase: small register range to make matches frequent.
        repeat (3000) begin
            tick();
            RST          = ($urandom_range(0, 199) != 0);
            Rs_id        = 5'($urandom_range(0, 3));
            Rt_id        = 5'($urandom_range(0, 3));
            WriteReg_ex  = 5'($urandom_range(0, 3));
            WriteReg_mem = 5'($urandom_range(0, 3));
            uses_rt_id   = 1'($urandom_range(0, 1));
            memread_ex   = 1'($urandom_range(0, 1));
            regwrite_ex  = 1'($urandom_range(0, 1));
            regwrite_mem = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
        end
        tick();
        RST = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
